// File: rtl/alu_mc.sv
// alu_mc: accumulator ALU with carry/zero flags, single-cycle logic/arith ops,
// and iterative shift-add multiply and bit-serial shifts behind a busy/done handshake.
module alu_mc #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_ce,
  input  logic             cy_ce,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] ext,
  output logic             cy,
  output logic             zf,
  output logic             busy,
  output logic             done
);
  localparam logic [3:0] OP_LD = 4'd1, OP_ADD = 4'd2, OP_ADC = 4'd3, OP_SUB = 4'd4,
                         OP_SBB = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7, OP_XOR = 4'd8,
                         OP_NOT = 4'd9, OP_SHL = 4'd10, OP_SHR = 4'd11, OP_MUL = 4'd12;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d, ext_q, ext_d, mplier_q, mplier_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, pp_q, pp_d;
  logic [SHW:0] cnt_q, cnt_d;
  logic cy_q, cy_d, zf_q, zf_d, busy_q, busy_d, done_q, done_d;
  logic dir_q, dir_d, cyce_q, cyce_d, fin, cin;
  logic [WIDTH:0] add_r, sub_r;
  logic [SHW-1:0] n;
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ext_d    = ext_q;
    mplier_d = mplier_q;
    mcand_d  = mcand_q;
    pp_d     = pp_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    dir_d    = dir_q;
    cyce_d   = cyce_q;
    fin      = 1'b0;
    n        = operand[SHW-1:0];
    cin      = (op == OP_ADC || op == OP_SBB) ? cy_q : 1'b0;
    add_r    = {1'b0, acc_q} + {1'b0, operand} + {{WIDTH{1'b0}}, cin};
    sub_r    = {1'b0, acc_q} - {1'b0, operand} - {{WIDTH{1'b0}}, cin};
    case (state_q)
      S_IDLE: if (alu_ce) begin
        cyce_d = cy_ce;
        case (op)
          OP_LD:  begin acc_d = operand; fin = 1'b1; end
          OP_ADD, OP_ADC: begin
            acc_d = add_r[WIDTH-1:0];
            cy_d  = cy_ce ? add_r[WIDTH] : cy_q;
            fin   = 1'b1;
          end
          OP_SUB, OP_SBB: begin
            acc_d = sub_r[WIDTH-1:0];
            cy_d  = cy_ce ? sub_r[WIDTH] : cy_q;
            fin   = 1'b1;
          end
          OP_AND: begin acc_d = acc_q & operand; fin = 1'b1; end
          OP_OR:  begin acc_d = acc_q | operand; fin = 1'b1; end
          OP_XOR: begin acc_d = acc_q ^ operand; fin = 1'b1; end
          OP_NOT: begin acc_d = ~operand; fin = 1'b1; end
          OP_SHL, OP_SHR: begin
            fin     = (n == '0);
            state_d = (n == '0) ? S_IDLE : S_SHIFT;
            cnt_d   = {1'b0, n};
            dir_d   = (op == OP_SHR);
          end
          OP_MUL: begin
            mcand_d  = {{WIDTH{1'b0}}, acc_q};
            mplier_d = operand;
            pp_d     = '0;
            cnt_d    = (SHW+1)'(WIDTH);
            state_d  = S_MUL;
          end
          default: ;
        endcase
      end
      S_SHIFT: begin
        acc_d = dir_q ? acc_q >> 1 : acc_q << 1;
        cnt_d = cnt_q - (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(1)) begin
          fin     = 1'b1;
          state_d = S_IDLE;
          cy_d    = cyce_q ? (dir_q ? acc_q[0] : acc_q[WIDTH-1]) : cy_q;
        end
      end
      S_MUL: begin
        pp_d     = pp_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - (SHW+1)'(1);
        if (cnt_q == (SHW+1)'(1)) begin
          fin     = 1'b1;
          state_d = S_IDLE;
          acc_d   = pp_d[WIDTH-1:0];
          ext_d   = pp_d[2*WIDTH-1:WIDTH];
          cy_d    = cyce_q ? |pp_d[2*WIDTH-1:WIDTH] : cy_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    zf_d   = fin ? (acc_d == '0) : zf_q;
    done_d = fin;
    busy_d = (state_d != S_IDLE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      ext_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      pp_q     <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      zf_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dir_q    <= 1'b0;
      cyce_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ext_q    <= ext_d;
      mplier_q <= mplier_d;
      mcand_q  <= mcand_d;
      pp_q     <= pp_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      zf_q     <= zf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dir_q    <= dir_d;
      cyce_q   <= cyce_d;
    end
  end
  assign acc  = acc_q;
  assign ext  = ext_q;
  assign cy   = cy_q;
  assign zf   = zf_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule
